// File: rtl/frame_tx_sequencer_pkg.sv
// frame_tx_sequencer_pkg: state encoding, ASCII constants and width helper
// shared by the frame sequencer and its character selector.
package frame_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ENVIA   = 3'd2,
        ESPERA  = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam logic [6:0] ZERO    = 7'h30;
    localparam logic [6:0] SPACE   = 7'h20;
    localparam logic [6:0] INVALID = 7'h3F;
    localparam logic [6:0] COMMA   = 7'h2C;
    localparam logic [6:0] HASH    = 7'h23;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_tx_if.sv
// frame_tx_if: partida/pronto character handshake between the frame
// sequencer (master) and the serial transmitter (slave).
interface frame_tx_if;
    logic       tx_partida;
    logic [6:0] tx_dados;
    logic       tx_pronto;

    modport master (output tx_partida, tx_dados, input tx_pronto);
    modport slave  (input tx_partida, tx_dados, output tx_pronto);
endinterface

// File: rtl/frame_tx_sequencer_char_sel.sv
// frame_char_sel: maps the current field/digit position of the snapshot to the
// ASCII character to send, applying separator, '?' and leading-zero blanking.
module frame_char_sel
    import frame_tx_sequencer_pkg::*;
#(
    parameter int         NUM_FIELDS = 2,
    parameter int         DIGITS     = 3,
    parameter logic [6:0] SEP_CHAR   = COMMA,
    parameter logic [6:0] END_CHAR   = HASH,
    parameter int         FW         = width_of(NUM_FIELDS),
    parameter int         DW         = width_of(DIGITS + 1)
) (
    input  logic [NUM_FIELDS*DIGITS*4-1:0] snap,
    input  logic [FW-1:0]                  fld,
    input  logic [DW-1:0]                  dig,
    input  logic                           seen,
    input  logic                           modo,
    output logic [6:0]                     ch
);
    logic [NUM_FIELDS*DIGITS*4-1:0] sh;
    logic [3:0] nib;
    logic sep;
    int pos;

    // digit 0 is the most significant nibble of the field
    always_comb begin
        sep = int'(dig) == DIGITS;
        pos = sep ? 0 : (int'(fld) * DIGITS + DIGITS - 1 - int'(dig)) * 4;
        sh  = snap >> pos;
        nib = sh[3:0];
        ch  = sep ? ((int'(fld) == NUM_FIELDS - 1) ? END_CHAR : SEP_CHAR) :
              (nib > 4'd9) ? INVALID :
              (modo && !seen && nib == 4'd0 && int'(dig) != DIGITS - 1) ? SPACE :
              ZERO | {3'b000, nib};
    end
endmodule

// File: rtl/frame_tx_sequencer.sv
// frame_tx_sequencer: snapshots NUM_FIELDS BCD fields on iniciar and streams
// them as ASCII characters, separators and a terminator over frame_tx_if.
module frame_tx_sequencer
    import frame_tx_sequencer_pkg::*;
#(
    parameter int         NUM_FIELDS = 2,
    parameter int         DIGITS     = 3,
    parameter logic [6:0] SEP_CHAR   = COMMA,
    parameter logic [6:0] END_CHAR   = HASH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic                           suprime_zeros,
    input  logic [NUM_FIELDS*DIGITS*4-1:0] campos,
    frame_tx_if.master                     tx,
    output logic                           ocupado,
    output logic                           pronto,
    output logic [2:0]                     db_estado
);
    localparam int L  = NUM_FIELDS * (DIGITS + 1);
    localparam int IW = $clog2(L);
    localparam int FW = width_of(NUM_FIELDS);
    localparam int DW = width_of(DIGITS + 1);
    localparam logic [IW-1:0] LAST = IW'(L - 1);

    estado_t estado, prox;
    logic [IW-1:0] idx;
    logic [FW-1:0] fld;
    logic [DW-1:0] dig;
    logic seen, modo, sep;
    logic [NUM_FIELDS*DIGITS*4-1:0] snap;
    logic [6:0] ch;

    assign sep = dig == DW'(DIGITS);

    frame_char_sel #(
        .NUM_FIELDS(NUM_FIELDS),
        .DIGITS    (DIGITS),
        .SEP_CHAR  (SEP_CHAR),
        .END_CHAR  (END_CHAR),
        .FW        (FW),
        .DW        (DW)
    ) u_char_sel (
        .snap(snap),
        .fld (fld),
        .dig (dig),
        .seen(seen),
        .modo(modo),
        .ch  (ch)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  prox = iniciar ? CARREGA : OCIOSO;
            CARREGA: prox = ENVIA;
            ENVIA:   prox = ESPERA;
            ESPERA:  prox = !tx.tx_pronto ? ESPERA : (idx == LAST) ? FIM : ENVIA;
            FIM:     prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
        tx.tx_partida = estado == ENVIA;
        tx.tx_dados   = (estado == ENVIA || estado == ESPERA) ? ch : 7'h00;
        ocupado       = estado != OCIOSO;
        pronto        = estado == FIM;
        db_estado     = estado;
    end

    // a nonzero or invalid digit (anything but '0'/' ') ends blanking for the field
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx  <= '0;
            fld  <= '0;
            dig  <= '0;
            seen <= 1'b0;
            modo <= 1'b0;
            snap <= '0;
        end else if (estado == OCIOSO && iniciar) begin
            snap <= campos;
            modo <= suprime_zeros;
        end else if (estado == CARREGA) begin
            idx  <= '0;
            fld  <= '0;
            dig  <= '0;
            seen <= 1'b0;
        end else if (estado == ESPERA && tx.tx_pronto && idx != LAST) begin
            idx  <= idx + 1'b1;
            fld  <= sep ? fld + 1'b1 : fld;
            dig  <= sep ? '0 : dig + 1'b1;
            seen <= !sep && (seen || (ch != ZERO && ch != SPACE));
        end
    end
endmodule

// File: doc/frame_tx_sequencer.md
# frame_tx_sequencer

Parametrised frame sequencer between the measurement datapath and the 7O1 serial transmitter. It snapshots `NUM_FIELDS` BCD fields of `DIGITS` digits each on a start pulse. It then emits them one ASCII character at a time through a partida/pronto handshake. Fields are separated by a configurable character and the frame ends with a terminator. This replaces the hard-wired distance/angle character muxes in the trena datapath. It adds leading-zero blanking, invalid-digit flagging and an explicit busy/done protocol.

## Interface
- `NUM_FIELDS`, default 2: fields per frame (≥1).
- `DIGITS`, default 3: BCD digits per field (≥1).
- `SEP_CHAR`, default 7'h2C (','): character emitted after every field except the last.
- `END_CHAR`, default 7'h23 ('#'): character emitted after the last field.
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `iniciar`, input, 1: start pulse; sampled only in OCIOSO.
- `suprime_zeros`, input, 1: leading-zero blanking mode; sampled together with `iniciar`.
- `campos`, input, NUM_FIELDS*DIGITS*4: field f occupies bits [(f+1)*DIGITS*4-1 : f*DIGITS*4]. Most significant nibble is sent first.
- `tx_pronto`, input, 1: one-cycle "character sent" pulse from the transmitter.
- `tx_partida`, output, 1: one-cycle request to the transmitter.
- `tx_dados`, output, 7: character to transmit.
- `ocupado`, output, 1: high from the snapshot until the frame completes.
- `pronto`, output, 1: one-cycle pulse after the terminator is acknowledged.
- `db_estado`, output, 3: current state encoding.

## Operation
- Frame = for f = 0..NUM_FIELDS-1: DIGITS characters, then SEP_CHAR (or END_CHAR if f is last). Length L = NUM_FIELDS*(DIGITS+1).
- Digit d (0–9) → 7'h30|d. Nibble > 9 → 7'h3F ('?'). An invalid nibble also terminates blanking for that field.
- Blanking (mode captured high): within each field, zero digits preceding the first nonzero digit → 7'h20 (space). The last digit of a field is never blanked, so 000 → "  0".
- `campos` and mode are copied into internal registers at start. Input changes during a frame have no effect.
- States:
  - OCIOSO: `iniciar` → CARREGA.
  - CARREGA: snapshot captured, index := 0 → ENVIA.
  - ENVIA: `tx_partida`=1 → ESPERA.
  - ESPERA: `tx_pronto` with index < L-1 → ENVIA, index+1. `tx_pronto` with index = L-1 → FIM.
  - FIM: `pronto`=1 → OCIOSO.
- `iniciar` outside OCIOSO is ignored; no queuing.
- `tx_pronto` outside ESPERA is ignored. This covers a pulse arriving in the same cycle as `tx_partida`.
- Reset (any state, mid-character included): state OCIOSO, index 0, snapshot cleared. All outputs 0: `tx_partida`, `tx_dados`=7'h00, `ocupado`, `pronto`, `db_estado`=0. A character in flight at the transmitter is abandoned.

## Timing
- All outputs are registered or Moore-decoded; no combinational path from any input to any output.
- `iniciar` high at edge E0 → CARREGA after E0.
- E1 → ENVIA; `tx_partida` high for exactly the cycle after E1.
- `tx_dados` is valid from the `tx_partida` cycle and held stable until the edge that samples `tx_pronto`.
- Inter-character gap: `tx_pronto` edge → next `tx_partida` one cycle later.
- `ocupado` is high from the cycle after E0 through the FIM cycle, inclusive.
- `pronto` is asserted in the FIM cycle, the cycle after the last `tx_pronto` edge. `ocupado` deasserts the cycle after FIM.
- A new `iniciar` is accepted in the first OCIOSO cycle after FIM.

## Structure
- Shared package holds:
  - state encoding: OCIOSO=0, CARREGA=1, ENVIA=2, ESPERA=3, FIM=4;
  - ASCII constants: ZERO 7'h30, SPACE 7'h20, INVALID 7'h3F, COMMA 7'h2C, HASH 7'h23.
- Index width = clog2(L). Field/digit position is decoded from the index by counters: digit counter 0..DIGITS and field counter 0..NUM_FIELDS-1. No divider.
- Blanking needs a per-field "nonzero seen" flag, cleared at each field start.
- One sub-module, `frame_char_sel`: combinational. Takes the snapshot, field/digit position, blanking flag and mode, and returns the 7-bit character.

## Test plan
- NUM_FIELDS=2, DIGITS=3, `campos`={12'h123,12'h045}, mode 0, transmitter model acks 10 cycles after each `tx_partida` → 30 34 35 2C 31 32 33 23. Exactly 8 `tx_partida` pulses, then one `pronto`, then `ocupado`=0.
- Same frame, mode 1, `campos`={12'h007,12'h045} → 20 34 35 2C 20 20 37 23. With {12'h000,12'h100} → 31 30 30 2C 20 20 30 23.
- Nibble 4'hA in the middle of field 0 (12'h0A5), mode 1 → 20 3F 35. The trailing digit is still '5', not blanked.
- `iniciar` pulsed again mid-frame and `campos` changed after start → output identical to the original frame. `tx_pronto` injected during CARREGA or ENVIA → ignored, no index skip.
- `reset` low while in ESPERA at character 4 → all outputs 0 within the same cycle. A restart yields the full frame from character 0.
- NUM_FIELDS=4, DIGITS=1, `campos`=16'h9876 → 36 2C 37 2C 38 2C 39 23.
